// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit.
// Contents: FSM state encoding and the performance counter width.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int unsigned CNT_W = 16;

endpackage : hazard_ctrl_unit_pkg

// File: rtl/hazard_ctrl_unit_sat_counter16.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk   - clock, counts on posedge
//   rst_n - asynchronous active-low clear
//   en    - count enable for this cycle
//   count - current value, sticks at all-ones
module sat_counter16
    import hazard_ctrl_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter16

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait handling with a sticky timeout flag.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt       - source operands of the instruction in ID
//   ex_mem_read, ex_rt             - load in EX and its destination register
//   branch_taken                   - ID resolved a taken branch/jump
//   dmem_busy                      - data memory not complete this cycle
//   hold, IF_flush                 - IF/ID hold, and flush (valid only with hold)
//   pc_write, id_ex_bubble         - PC enable, NOP insertion into ID/EX
//   stall_count, flush_count       - saturating performance counters
//   mem_timeout                    - sticky memory-wait timeout error
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             hold,
    output logic             IF_flush,
    output logic             pc_write,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam logic [1:0] LU_LOAD = 2'(LU_CYCLES - 1);
    localparam logic [7:0] TO_LIM  = 8'(MEM_TIMEOUT);

    hz_state_t  state, state_nx;
    logic [1:0] lu_cnt, lu_cnt_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       timeout_nx;
    logic       lu_hazard;

    assign lu_hazard = ex_mem_read && (ex_rt != '0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        hold         = 1'b0;
        IF_flush     = 1'b0;
        pc_write     = 1'b1;
        id_ex_bubble = 1'b0;
        state_nx     = state;
        lu_cnt_nx    = lu_cnt;
        wait_cnt_nx  = wait_cnt;

        // MEM_WAIT with memory ready falls through to the same priority
        // evaluation as RUN; a timed-out unit stays frozen in MEM_WAIT.
        if ((state == RUN) ||
            ((state == MEM_WAIT) && !dmem_busy && !mem_timeout)) begin
            wait_cnt_nx = '0;
            state_nx    = RUN;
            if (dmem_busy) begin
                hold        = 1'b1;
                pc_write    = 1'b0;
                wait_cnt_nx = 8'd1;
                state_nx    = MEM_WAIT;
            end else if (lu_hazard) begin
                hold         = 1'b1;
                pc_write     = 1'b0;
                id_ex_bubble = 1'b1;
                lu_cnt_nx    = LU_LOAD;
                state_nx     = (LU_CYCLES > 1) ? LU_STALL : RUN;
            end else if (branch_taken) begin
                hold     = 1'b1;
                IF_flush = 1'b1;
            end
        end else if (state == LU_STALL) begin
            hold     = 1'b1;
            pc_write = 1'b0;
            if (dmem_busy) begin
                wait_cnt_nx = 8'd1;
                state_nx    = MEM_WAIT;
            end else begin
                id_ex_bubble = 1'b1;
                lu_cnt_nx    = lu_cnt - 2'd1;
                // lu_cnt reaches 0 at this edge, so RUN follows.
                if (lu_cnt <= 2'd1) begin
                    state_nx = RUN;
                end
            end
        end else if (state == MEM_WAIT) begin
            hold     = 1'b1;
            pc_write = 1'b0;
            if (dmem_busy && (wait_cnt != 8'hFF)) begin
                wait_cnt_nx = wait_cnt + 8'd1;
            end
        end else begin
            state_nx = RUN;
        end

        // wait_cnt counts every busy cycle, including the one that enters MEM_WAIT.
        timeout_nx = mem_timeout || (dmem_busy && (wait_cnt_nx == TO_LIM));

        if (!rst_n) begin
            hold         = 1'b0;
            IF_flush     = 1'b0;
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            lu_cnt      <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            lu_cnt      <= lu_cnt_nx;
            wait_cnt    <= wait_cnt_nx;
            mem_timeout <= timeout_nx;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hold && !IF_flush),
        .count (stall_count)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (IF_flush),
        .count (flush_count)
    );

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit. Two instances share
// stimulus: d1 (LU_CYCLES=1, MEM_TIMEOUT=8) and d3 (LU_CYCLES=3, default timeout).
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, branch_taken, dmem_busy;

    logic        h1, f1, p1, b1, mt1;
    logic [15:0] sc1, fc1;
    logic        h3, f3, p3, b3, mt3;
    logic [15:0] sc3, fc3;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LU_CYCLES(1), .MEM_TIMEOUT(8)) d1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .hold(h1), .IF_flush(f1), .pc_write(p1), .id_ex_bubble(b1),
        .stall_count(sc1), .flush_count(fc1), .mem_timeout(mt1)
    );

    hazard_ctrl_unit #(.LU_CYCLES(3)) d3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .hold(h3), .IF_flush(f3), .pc_write(p3), .id_ex_bubble(b3),
        .stall_count(sc3), .flush_count(fc3), .mem_timeout(mt3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control outputs packed as {hold, IF_flush, pc_write, id_ex_bubble}.
    function automatic logic [31:0] ctl1();
        return {28'd0, h1, f1, p1, b1};
    endfunction

    function automatic logic [31:0] ctl3();
        return {28'd0, h3, f3, p3, b3};
    endfunction

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        chk("rst_ctl",   ctl1(), 32'b0001);
        chk("rst_sc",    32'(sc1), 32'd0);
        chk("rst_fc",    32'(fc1), 32'd0);
        chk("rst_mt",    32'(mt1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs: d1 stalls 1 cycle, d3 stalls 3 cycles.
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk("lu1_c1",   ctl1(), 32'b1001);
        chk("lu3_c1",   ctl3(), 32'b1001);
        @(negedge clk);
        idle();
        #1;
        chk("lu1_done", ctl1(), 32'b0010);
        chk("lu1_sc",   32'(sc1), 32'd1);
        chk("lu3_c2",   ctl3(), 32'b1001);
        @(negedge clk);
        #1;
        chk("lu3_c3",   ctl3(), 32'b1001);
        @(negedge clk);
        #1;
        chk("lu3_done", ctl3(), 32'b0010);
        chk("lu3_sc",   32'(sc3), 32'd3);

        // Register-zero and rt-qualification cases.
        do_reset();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("rt0_nostall", ctl1(), 32'b0010);
        @(negedge clk);
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
        #1;
        chk("rt_unused",   ctl1(), 32'b0010);
        @(negedge clk);
        id_uses_rt = 1'b1;
        #1;
        chk("rt_used",     ctl1(), 32'b1001);
        @(negedge clk);
        idle();
        #1;
        chk("rt_sc",       32'(sc1), 32'd1);

        // Taken branch in RUN.
        do_reset();
        @(negedge clk);
        branch_taken = 1'b1;
        #1;
        chk("br_ctl",   ctl1(), 32'b1110);
        @(negedge clk);
        idle();
        #1;
        chk("br_after", ctl1(), 32'b0010);
        chk("br_fc",    32'(fc1), 32'd1);
        chk("br_sc",    32'(sc1), 32'd0);

        // Branch held during a 4-cycle memory wait: flush only after it.
        do_reset();
        @(negedge clk);
        branch_taken = 1'b1; dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw_br_%0d", i), ctl1(), 32'b1000);
            @(negedge clk);
        end
        dmem_busy = 1'b0;
        #1;
        chk("mw_br_flush", ctl1(), 32'b1110);
        @(negedge clk);
        idle();
        #1;
        chk("mw_br_after", ctl1(), 32'b0010);
        chk("mw_br_fc",    32'(fc1), 32'd1);
        chk("mw_br_sc",    32'(sc1), 32'd4);
        chk("mw_br_mt",    32'(mt1), 32'd0);

        // Stuck memory: d1 times out after 8 busy cycles, d3 does not.
        do_reset();
        @(negedge clk);
        dmem_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to1_%0d", i), 32'(mt1), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("to3_none", 32'(mt3), 32'd0);
        @(negedge clk);
        dmem_busy = 1'b0;
        #1;
        chk("to1_locked", ctl1(), 32'b1000);
        chk("to3_free",   ctl3(), 32'b0010);
        @(negedge clk);
        #1;
        chk("to1_sticky", 32'(mt1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("to1_rst_mt",  32'(mt1), 32'd0);
        chk("to1_rst_ctl", ctl1(), 32'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("to1_run",     ctl1(), 32'b0010);

        // Reset in the middle of a d3 load-use stall.
        do_reset();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        @(negedge clk);
        idle();
        #1;
        chk("mid_stall",   ctl3(), 32'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", ctl3(), 32'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_release", ctl3(), 32'b0010);
        chk("mid_sc",      32'(sc3), 32'd0);
        @(negedge clk);
        #1;
        chk("mid_after",   ctl3(), 32'b0010);

        // Counter saturation: a locked MEM_WAIT stalls every cycle.
        do_reset();
        @(negedge clk);
        dmem_busy = 1'b1;
        repeat (65600) @(negedge clk);
        #1;
        chk("sat_sc1", 32'(sc1), 32'h0000FFFF);
        chk("sat_sc3", 32'(sc3), 32'h0000FFFF);
        chk("sat_mt3", 32'(mt3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl_unit

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter LU_CYCLES, default 1, range 1-3: load-use stall length in cycles.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: MEM_WAIT cycle limit before the timeout flag is set.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 id_rs, id_rt  in  5 each  source registers of the instruction held in IF/ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt.
REQ-007 ex_mem_read, ex_rt  in  1, 5  EX-stage load flag and load destination.
REQ-008 branch_taken  in  1  ID resolves a taken branch or jump.
REQ-009 dmem_busy  in  1  data memory is not complete this cycle.
REQ-010 hold  out  1  IF/ID hold; 1 = IF/ID keeps its contents unless IF_flush=1.
REQ-011 IF_flush  out  1  IF/ID flush; takes effect only while hold=1.
REQ-012 pc_write, id_ex_bubble  out  1 each  PC enable; insert NOP into ID/EX.
REQ-013 stall_count, flush_count  out  16 each  saturating performance counters.
REQ-014 mem_timeout  out  1  sticky timeout error flag.

Function
REQ-015 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, with control outputs decoded combinationally from state and inputs.
REQ-016 SHALL define load-use hazard = ex_mem_read and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
REQ-017 SHALL resolve RUN priority in this order: dmem_busy, then load-use hazard, then branch_taken, then normal flow.
REQ-018 RUN, dmem_busy=1: hold=1, pc_write=0, id_ex_bubble=0, IF_flush=0; next state MEM_WAIT.
REQ-019 RUN, hazard: hold=1, pc_write=0, id_ex_bubble=1, IF_flush=0; load lu_cnt with LU_CYCLES-1; next state LU_STALL if LU_CYCLES>1, else RUN.
REQ-020 LU_STALL: same outputs as REQ-019; lu_cnt decrements each cycle; return to RUN the cycle after lu_cnt reaches 0; dmem_busy=1 overrides to MEM_WAIT.
REQ-021 RUN, branch_taken only: hold=1, IF_flush=1, pc_write=1, id_ex_bubble=0; stay in RUN.
REQ-022 RUN, no event: hold=0, IF_flush=0, pc_write=1, id_ex_bubble=0.
REQ-023 IF_flush SHALL never assert without hold=1, and SHALL never assert in LU_STALL or MEM_WAIT; a branch during a stall is flushed after return to RUN, because ID is frozen and branch_taken persists.
REQ-024 MEM_WAIT, dmem_busy=1: outputs as REQ-018; the 8-bit wait_cnt increments.
REQ-025 MEM_WAIT, dmem_busy=0: outputs and next state as RUN evaluation; wait_cnt cleared.
REQ-026 SHALL set mem_timeout when wait_cnt reaches MEM_TIMEOUT; mem_timeout holds until reset, and the FSM stays in MEM_WAIT.
REQ-027 stall_count SHALL increment each cycle with hold=1 and IF_flush=0, and flush_count each cycle with IF_flush=1; both saturate at 16'hFFFF, never wrap.

Reset
REQ-028 rst_n low SHALL asynchronously force state RUN, lu_cnt=0, wait_cnt=0, both counters 0, and mem_timeout=0.
REQ-029 While rst_n is low, outputs SHALL be hold=0, IF_flush=0, pc_write=0, id_ex_bubble=1.
REQ-030 Reset asserted mid-stall SHALL abandon the stall with no residual flush or bubble after release.

Structure
REQ-031 State encoding (RUN=0, LU_STALL=1, MEM_WAIT=2) and the 16-bit counter width SHALL live in the shared pipeline package.
REQ-032 One sub-module, sat_counter16 (enable, async active-low clear), SHALL be instantiated twice.

Verification
REQ-033 ex_mem_read=1, ex_rt=5, id_rs=5, LU_CYCLES=1 -> one cycle hold=1, bubble=1, pc_write=0; stall_count=1.
REQ-034 LU_CYCLES=3, same hazard -> exactly 3 stall cycles, then RUN; stall_count=3.
REQ-035 ex_rt=0 matching id_rs=0 -> no stall.
REQ-036 branch_taken=1 in RUN -> hold=1, IF_flush=1, pc_write=1 for one cycle; flush_count=1.
REQ-037 dmem_busy high 4 cycles with branch_taken=1 -> IF_flush=0 for those 4 cycles, then one flush cycle; mem_timeout stays 0.
REQ-038 dmem_busy stuck high, MEM_TIMEOUT=8 -> mem_timeout=1 after 8 cycles; rst_n pulse clears it and forces state RUN.
